// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one functional-unit result per cycle is
// registered onto cdb_* for the reg file write, ready-table wakeup and ROB complete.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ         = 3,
    parameter int unsigned PHYS_REG_WIDTH  = 6,
    parameter int unsigned ROB_INDEX_WIDTH = 5,
    parameter int unsigned WORD_WIDTH      = 32
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_reg_write,
    input  logic [NUM_REQ*PHYS_REG_WIDTH-1:0]   req_phys_reg_tag,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]       req_data,
    input  logic [NUM_REQ*ROB_INDEX_WIDTH-1:0]  req_ROB_index,
    input  logic                                cdb_stall,
    input  logic                                cdb_flush,
    output logic                                cdb_valid,
    output logic                                cdb_reg_write,
    output logic [PHYS_REG_WIDTH-1:0]           cdb_phys_reg_tag,
    output logic [WORD_WIDTH-1:0]               cdb_data,
    output logic [ROB_INDEX_WIDTH-1:0]          cdb_ROB_index,
    output logic [1:0]                          cdb_grant_id
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           gnt_idx;
    logic [PTR_W-1:0]           idx;
    logic                       found;
    logic                       load_en;
    logic                       transfer;
    logic                       sel_reg_write;
    logic [PHYS_REG_WIDTH-1:0]  sel_tag;
    logic [WORD_WIDTH-1:0]      sel_data;
    logic [ROB_INDEX_WIDTH-1:0] sel_rob;

    // The output register may only be overwritten when it is empty or draining.
    assign load_en  = !cdb_flush && (!cdb_valid || !cdb_stall);
    assign transfer = load_en && found;

    // Scan from rr_ptr upward (mod NUM_REQ); the first valid requester wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = nRST && transfer && (gnt_idx == PTR_W'(i));
        end
    end

    always_comb begin
        sel_reg_write = 1'b0;
        sel_tag       = '0;
        sel_data      = '0;
        sel_rob       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                sel_reg_write = req_reg_write[i];
                sel_tag       = req_phys_reg_tag[i*PHYS_REG_WIDTH +: PHYS_REG_WIDTH];
                sel_data      = req_data[i*WORD_WIDTH +: WORD_WIDTH];
                sel_rob       = req_ROB_index[i*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr           <= '0;
            cdb_valid        <= 1'b0;
            cdb_reg_write    <= 1'b0;
            cdb_phys_reg_tag <= '0;
            cdb_data         <= '0;
            cdb_ROB_index    <= '0;
            cdb_grant_id     <= '0;
        end else if (cdb_flush) begin
            cdb_valid <= 1'b0;
        end else if (transfer) begin
            cdb_valid        <= 1'b1;
            cdb_reg_write    <= sel_reg_write;
            cdb_phys_reg_tag <= sel_tag;
            cdb_data         <= sel_data;
            cdb_ROB_index    <= sel_rob;
            cdb_grant_id     <= 2'(gnt_idx);
            rr_ptr           <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (load_en) begin
            cdb_valid <= 1'b0;
        end
        // Otherwise stalled with a valid result: hold everything.
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter against a distance-based round-robin model.
module tb_cdb_arbiter;

    localparam int N   = 3;
    localparam int PRW = 6;
    localparam int RIW = 5;
    localparam int WW  = 32;

    logic                CLK;
    logic                nRST;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        req_reg_write;
    logic [N*PRW-1:0]    req_phys_reg_tag;
    logic [N*WW-1:0]     req_data;
    logic [N*RIW-1:0]    req_ROB_index;
    logic                cdb_stall;
    logic                cdb_flush;
    logic                cdb_valid;
    logic                cdb_reg_write;
    logic [PRW-1:0]      cdb_phys_reg_tag;
    logic [WW-1:0]       cdb_data;
    logic [RIW-1:0]      cdb_ROB_index;
    logic [1:0]          cdb_grant_id;

    logic [PRW-1:0] r_tag  [N];
    logic [WW-1:0]  r_data [N];
    logic [RIW-1:0] r_rob  [N];

    // Reference model state
    int             m_ptr;
    logic           m_valid;
    logic           m_rw;
    logic [PRW-1:0] m_tag;
    logic [WW-1:0]  m_data;
    logic [RIW-1:0] m_rob;
    int             m_gid;
    int             last_win;
    int             wait_cnt [N];
    bit             rand_mode;

    int tests;
    int fails;

    cdb_arbiter #(
        .NUM_REQ        (N),
        .PHYS_REG_WIDTH (PRW),
        .ROB_INDEX_WIDTH(RIW),
        .WORD_WIDTH     (WW)
    ) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_reg_write   (req_reg_write),
        .req_phys_reg_tag(req_phys_reg_tag),
        .req_data        (req_data),
        .req_ROB_index   (req_ROB_index),
        .cdb_stall       (cdb_stall),
        .cdb_flush       (cdb_flush),
        .cdb_valid       (cdb_valid),
        .cdb_reg_write   (cdb_reg_write),
        .cdb_phys_reg_tag(cdb_phys_reg_tag),
        .cdb_data        (cdb_data),
        .cdb_ROB_index   (cdb_ROB_index),
        .cdb_grant_id    (cdb_grant_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        req_phys_reg_tag = '0;
        req_data         = '0;
        req_ROB_index    = '0;
        for (int i = 0; i < N; i++) begin
            req_phys_reg_tag[i*PRW +: PRW] = r_tag[i];
            req_data[i*WW +: WW]           = r_data[i];
            req_ROB_index[i*RIW +: RIW]    = r_rob[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic new_payload(input int i);
        r_tag[i]  = PRW'($urandom);
        r_data[i] = $urandom;
        r_rob[i]  = RIW'($urandom);
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_rw    = 1'b0;
        m_tag   = '0;
        m_data  = '0;
        m_rob   = '0;
        m_gid   = 0;
    endtask

    // Winner = valid requester with the smallest circular distance from the priority pointer.
    function automatic int model_winner();
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = N;
        if (!nRST || cdb_flush || (m_valid && cdb_stall)) return -1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
                d = (i - m_ptr + N) % N;
                if (d < best_d) begin
                    best_d = d;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    task automatic check_outputs();
        chk("cdb_valid", cdb_valid, m_valid);
        if (m_valid) begin
            chk("cdb_reg_write", cdb_reg_write, m_rw);
            chk("cdb_tag", cdb_phys_reg_tag, m_tag);
            chk("cdb_data", cdb_data, m_data);
            chk("cdb_rob", cdb_ROB_index, m_rob);
            chk("cdb_gid", cdb_grant_id, m_gid);
        end
    endtask

    task automatic cycle();
        int w;
        logic [N-1:0] er;
        #1;
        w  = model_winner();
        er = (w >= 0) ? (N'(1) << w) : '0;
        chk("req_ready", req_ready, er);
        @(posedge CLK);
        if (!nRST) begin
            model_reset();
        end else if (cdb_flush) begin
            m_valid = 1'b0;
        end else if (w >= 0) begin
            m_valid = 1'b1;
            m_rw    = req_reg_write[w];
            m_tag   = r_tag[w];
            m_data  = r_data[w];
            m_rob   = r_rob[w];
            m_gid   = w;
            m_ptr   = (w + 1) % N;
        end else if (!(m_valid && cdb_stall)) begin
            m_valid = 1'b0;
        end
        if (rand_mode && w >= 0) begin
            chk("fairness", (wait_cnt[w] <= N - 1), 1);
            for (int i = 0; i < N; i++) begin
                if (i != w && req_valid[i]) wait_cnt[i]++;
            end
            wait_cnt[w] = 0;
        end
        last_win = w;
        #1;
        check_outputs();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rand_mode = 1'b0;
        last_win  = -1;
        for (int i = 0; i < N; i++) begin
            new_payload(i);
            wait_cnt[i] = 0;
        end
        model_reset();
        nRST          = 1'b0;
        req_valid     = '1;
        req_reg_write = '1;
        cdb_stall     = 1'b0;
        cdb_flush     = 1'b0;

        // Reset with every requester asserting valid
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", cdb_valid, 0);
        chk("rst_tag", cdb_phys_reg_tag, 0);
        chk("rst_data", cdb_data, 0);
        chk("rst_rob", cdb_ROB_index, 0);
        chk("rst_gid", cdb_grant_id, 0);
        cycle();
        cycle();
        nRST = 1'b1;

        // All valid: strict rotation 0,1,2,0,1,2
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rotation_gid", cdb_grant_id, k % N);
            chk("rotation_valid", cdb_valid, 1);
            new_payload(last_win);
        end

        // Lone requester 2 with pointer at 0
        req_valid = 3'b100;
        r_tag[2]  = 6'h2A;
        r_data[2] = 32'hDEADBEEF;
        r_rob[2]  = 5'h13;
        cycle();
        chk("lone_valid", cdb_valid, 1);
        chk("lone_tag", cdb_phys_reg_tag, 6'h2A);
        chk("lone_data", cdb_data, 32'hDEADBEEF);
        chk("lone_rob", cdb_ROB_index, 5'h13);
        chk("lone_gid", cdb_grant_id, 2);

        // Stall for 3 cycles while holding the result
        req_valid = 3'b011;
        new_payload(0);
        new_payload(1);
        cdb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_hold_data", cdb_data, 32'hDEADBEEF);
            chk("stall_hold_gid", cdb_grant_id, 2);
        end
        cdb_stall = 1'b0;
        cycle();
        chk("unstall_gid", cdb_grant_id, 0);

        // Flush wins over stall; requester 1 goes next
        req_valid = 3'b010;
        cdb_stall = 1'b1;
        cdb_flush = 1'b1;
        cycle();
        chk("flush_valid", cdb_valid, 0);
        cdb_stall = 1'b0;
        cdb_flush = 1'b0;
        cycle();
        chk("post_flush_valid", cdb_valid, 1);
        chk("post_flush_gid", cdb_grant_id, 1);

        // Store-like completion from requester 1
        req_valid     = 3'b011;
        req_reg_write = 3'b101;
        new_payload(0);
        new_payload(1);
        cycle();
        chk("rw0_gid", cdb_grant_id, 0);
        chk("rw0_write", cdb_reg_write, 1);
        new_payload(0);
        cycle();
        chk("rw1_gid", cdb_grant_id, 1);
        chk("rw1_write", cdb_reg_write, 0);
        chk("rw1_valid", cdb_valid, 1);
        req_reg_write = '1;

        // Reset while stalled drops the held result
        cdb_stall = 1'b1;
        cycle();
        nRST = 1'b0;
        #1;
        chk("midrst_valid", cdb_valid, 0);
        chk("midrst_ready", req_ready, 0);
        model_reset();
        #1;
        nRST      = 1'b1;
        cdb_stall = 1'b0;
        req_valid = '0;
        cycle();

        // Randomized traffic obeying valid/payload hold until transfer
        rand_mode = 1'b1;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    new_payload(i);
                    req_reg_write[i] = 1'($urandom_range(1, 0));
                    req_valid[i]     = 1'b1;
                    wait_cnt[i]      = 0;
                end
            end
            cdb_stall = ($urandom_range(3, 0) == 0);
            cdb_flush = ($urandom_range(9, 0) == 0);
            cycle();
            if (last_win >= 0) req_valid = req_valid & ~(N'(1) << last_win);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the single writeback/complete bus (CDB).
- Functional-unit results (ALU_0, ALU_1, LQ by default) compete for the bus.
- The winning result is registered for one cycle, then drives three consumers: the phys reg file write port, the phys reg ready-table wakeup, and the ROB complete.
- Sits between the functional-unit pipelines and the shared writeback resources.

Parameters:
- NUM_REQ, 3, number of requesting units; index 0=ALU_0, 1=ALU_1, 2=LQ.
- PHYS_REG_WIDTH, 6, phys reg tag width (64 phys regs).
- ROB_INDEX_WIDTH, 5, ROB index width (LOG_ROB_DEPTH+1, includes wrap bit).
- WORD_WIDTH, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a result.
- req_ready  out  NUM_REQ  combinational grant; one-hot or zero.
- req_reg_write  in  NUM_REQ  result writes a phys reg.
- req_phys_reg_tag  in  NUM_REQ*PHYS_REG_WIDTH  dest tags, requester i at slice i.
- req_data  in  NUM_REQ*WORD_WIDTH  result data.
- req_ROB_index  in  NUM_REQ*ROB_INDEX_WIDTH  ROB index of the result.
- cdb_stall  in  1  downstream cannot accept this cycle (e.g. ROB restore).
- cdb_flush  in  1  squash the held result and block new grants this cycle.
- cdb_valid  out  1  registered bus valid.
- cdb_reg_write  out  1  registered; qualifies the reg file write and wakeup.
- cdb_phys_reg_tag  out  PHYS_REG_WIDTH  registered.
- cdb_data  out  WORD_WIDTH  registered.
- cdb_ROB_index  out  ROB_INDEX_WIDTH  registered.
- cdb_grant_id  out  2  registered index of the source requester.

Behaviour:
- State:
  - rr_ptr, range 0..NUM_REQ-1: highest-priority requester.
  - Output register: cdb_* fields.
- Reset (nRST low, asynchronous):
  - rr_ptr=0.
  - cdb_valid=0, cdb_reg_write=0, cdb_phys_reg_tag=0, cdb_data=0, cdb_ROB_index=0, cdb_grant_id=0.
  - req_ready=0 while nRST is low.
- load_en = !cdb_flush && (!cdb_valid || !cdb_stall).
- Grant (combinational):
  - If load_en, search i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first i with req_valid[i] gets req_ready[i]=1; all other ready bits are 0.
  - If !load_en, all req_ready=0.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - The requester holds valid and its payload stable until the transfer.
  - Latency is 1 cycle: the transferred payload appears on cdb_* the next cycle with cdb_valid=1.
- Output register update, in priority order:
  1. cdb_flush: cdb_valid<=0; other fields don't-care/hold; rr_ptr unchanged.
  2. Transfer: cdb_* <= payload of i; cdb_grant_id<=i; rr_ptr <= (i+1) mod NUM_REQ.
  3. load_en with no requests: cdb_valid<=0; rr_ptr unchanged.
  4. Stall (cdb_valid && cdb_stall): hold all cdb_* fields; no grant.
- Back-to-back transfers, one per cycle, when unstalled.
- Fairness: a continuously valid requester is granted within NUM_REQ transfers.
- Single requester: granted every unstalled cycle.
- Simultaneous stall and flush: flush wins; cdb_valid clears.
- Reset mid-stall: the held result is lost. The ROB re-dispatch after restore covers this case.
- Wrap-around: rr_ptr after NUM_REQ-1 is 0.
- cdb_reg_write passes through unchanged. Consumers qualify wakeup and reg write with cdb_valid && cdb_reg_write; ROB complete uses cdb_valid only.

Test Plan:
- Reset: nRST=0 with all req_valid=1 -> all req_ready=0, cdb_valid=0, rr_ptr=0. Release -> cycle 1 grants req 0.
- All three valid for 6 cycles, no stall -> grants in order 0,1,2,0,1,2. cdb_grant_id follows one cycle later with matching tag, data and ROB_index.
- Only req 2 valid, tag 0x2A, data 0xDEADBEEF, ROB 0x13 -> next cycle cdb_valid=1 with those values. With rr_ptr=0, the grant sets rr_ptr=0 (wrap).
- cdb_stall=1 for 3 cycles while cdb_valid=1, reqs 0 and 1 valid -> req_ready=0 and cdb_* held. Stall drop -> req at rr_ptr granted the same cycle.
- cdb_flush=1 with cdb_valid=1 and cdb_stall=1, req 1 valid -> next cycle cdb_valid=0, req_ready=0 during the flush, rr_ptr unchanged. Req 1 is granted the following cycle.
- req 0 and 1 valid, req_reg_write=0 on 1 (store-like completion) -> cdb_reg_write=0 with cdb_valid=1 for that transfer; ordering is unaffected.
